// File: rtl/board_pkg.sv
// Board-wide constants shared by the switch conditioning logic.
// Clock rate and default debounce time for the board oscillator.
package board_pkg;

  localparam int BOARD_CLK_HZ        = 100_000_000;
  localparam int DEBOUNCE_US_DEFAULT = 10_000;

  // Width needed to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-FF synchroniser, stability counter and
// registered rise/fall pulses on the accepted level.
module debounce_channel #(
  parameter int CNT_MAX = 7,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CNT_MAX);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous level into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for LIMIT+1 edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (cnt < LIMIT) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt   <= '0;
        clean <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces raw board switches/buttons, one independent channel
// per input bit, with clean level and one-cycle edge pulses.
module switch_debouncer
  import board_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CLK_HZ      = BOARD_CLK_HZ,
  parameter int DEBOUNCE_US = DEBOUNCE_US_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sw_raw,
  output logic [CHANNELS-1:0] sw_clean,
  output logic [CHANNELS-1:0] sw_rise,
  output logic [CHANNELS-1:0] sw_fall
);

  localparam int CNT_MAX = CLK_HZ / 1_000_000 * DEBOUNCE_US - 1;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  // Replicate one self-contained debouncer per input bit.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .CNT_MAX(CNT_MAX),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (sw_raw[i]),
      .clean(sw_clean[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: CNT_MAX=7, so a level sampled at
// edge N is accepted at edge N+9; pulse events are scoreboarded.
module tb_switch_debouncer;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] clean;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_raw;
  logic [3:0] sw_clean;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;

  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [3:0] exp_clean;
  ev_t        q[$];

  switch_debouncer #(
    .CHANNELS   (4),
    .CLK_HZ     (1_000_000),
    .DEBOUNCE_US(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {20'd0, sw_clean, sw_rise, sw_fall}, 32'd0);
  endtask

  // Expected pulse event at edge c; tracks the clean level after it.
  task automatic push_ev(input int c, input logic [3:0] r,
                         input logic [3:0] f);
    ev_t e;
    exp_clean = (exp_clean | r) & ~f;
    e.cyc   = c;
    e.rise  = r;
    e.fall  = f;
    e.clean = exp_clean;
    q.push_back(e);
  endtask

  // Monitor: every cycle with any pulse must match the next event.
  always @(negedge clk) begin
    if ((sw_rise | sw_fall) != 4'd0) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cyc %0d rise %h fall %h",
                 cyc, sw_rise, sw_fall);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.rise !== sw_rise ||
            e.fall !== sw_fall || e.clean !== sw_clean) begin
          n_fail++;
          $display({"FAIL pulse_event: got cyc %0d r %h f %h c %h,",
                    " expected cyc %0d r %h f %h c %h"},
                   cyc, sw_rise, sw_fall, sw_clean,
                   e.cyc, e.rise, e.fall, e.clean);
        end
      end
    end
  end

  initial begin
    int lens[3];
    lens = '{7, 8, 9};
    rst       = 1'b1;
    sw_raw    = 4'hF;
    exp_clean = 4'h0;

    // Reset with all switches high, then power-up rise.
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_zero("reset_outputs");
    end
    rst = 1'b0;
    push_ev(cyc + 10, 4'hF, 4'h0);
    step(8);
    chk("clean_before_accept", {28'd0, sw_clean}, 32'h0);
    step(6);
    chk("clean_after_reset", {28'd0, sw_clean}, {28'd0, exp_clean});

    // All low, then ch0 rise and fall.
    sw_raw = 4'h0;
    push_ev(cyc + 10, 4'h0, 4'hF);
    step(14);
    sw_raw[0] = 1'b1;
    push_ev(cyc + 10, 4'h1, 4'h0);
    step(14);
    chk("ch0_high", {28'd0, sw_clean}, 32'h1);
    sw_raw[0] = 1'b0;
    push_ev(cyc + 10, 4'h0, 4'h1);
    step(14);
    chk("ch0_low", {28'd0, sw_clean}, 32'h0);

    // ch1 pulses of 7 (rejected), 8 and 9 (accepted) cycles.
    foreach (lens[j]) begin
      sw_raw[1] = 1'b1;
      if (lens[j] >= 8) push_ev(cyc + 10, 4'h2, 4'h0);
      step(lens[j]);
      sw_raw[1] = 1'b0;
      if (lens[j] >= 8) push_ev(cyc + 10, 4'h0, 4'h2);
      step(14);
      chk("ch1_pulse_len", {28'd0, sw_clean}, 32'h0);
    end

    // ch2 bounces every 3 cycles, then settles high.
    for (int i = 0; i < 10; i++) begin
      sw_raw[2] = ~sw_raw[2];
      step(3);
    end
    chk("ch2_bounce_rejected", {28'd0, sw_clean}, 32'h0);
    sw_raw[2] = 1'b1;
    push_ev(cyc + 10, 4'h4, 4'h0);
    step(14);
    chk("ch2_settled", {28'd0, sw_clean}, 32'h4);

    // Reset at count 5 of a ch3 rise discards the partial count.
    sw_raw = 4'h0;
    push_ev(cyc + 10, 4'h0, 4'h4);
    step(14);
    sw_raw[3] = 1'b1;
    step(7);
    rst = 1'b1;
    step(1);
    chk_zero("midcount_reset");
    step(1);
    chk_zero("midcount_reset");
    rst       = 1'b0;
    exp_clean = 4'h0;
    push_ev(cyc + 10, 4'h8, 4'h0);
    step(8);
    chk("ch3_not_yet", {28'd0, sw_clean}, 32'h0);
    step(6);
    chk("ch3_after_reset", {28'd0, sw_clean}, 32'h8);

    // ch0 and ch3 change together; ch3 bounces once.
    sw_raw = 4'h1;
    push_ev(cyc + 10, 4'h1, 4'h0);
    step(3);
    sw_raw[3] = 1'b1;
    step(2);
    sw_raw[3] = 1'b0;
    push_ev(cyc + 10, 4'h0, 4'h8);
    step(14);
    chk("two_channels", {28'd0, sw_clean}, 32'h1);

    step(5);
    chk("events_pending", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
